// File: rtl/hangman_round_ctrl.sv
// ---------------------------------------------------------------------------
// hangman_round_ctrl
//
// Round controller for a hangman game. A guessed letter is accepted on a
// valid/ready handshake. The controller then walks the secret word one
// position per cycle through an external word store and reveals matching
// positions. Finally it charges a try on a miss and decides win / lose.
//
// Parameters
//   WORD_LEN   number of letters in the secret word (1..8, 3-bit index)
//   MAX_TRIES  wrong guesses allowed per game (1..7)
//
// Ports
//   clk           sole clock, rising edge
//   rst           asynchronous, active-high reset
//   new_game      synchronous restart, wins over everything else
//   char_valid    guess letter presented
//   char_in       guess letter, 0..25 = A..Z, 26..31 invalid
//   char_ready    guess can be accepted (IDLE and no new_game)
//   word_index    position requested from the word store (0 outside SCAN)
//   word_char     letter at word_index, combinational from the store
//   guessed_mask  bit i set once position i has been revealed
//   tries_left    remaining wrong guesses
//   busy          guess evaluation in progress (SCAN or UPDATE)
//   win, lose     registered game result flags
//
// Optional feature (macro HANGMAN_REPEAT_GUARD_EN)
//   When the macro is defined, a 26-bit used-letter record is kept. A letter
//   that was already accepted is consumed without a scan and without a
//   penalty. When the macro is undefined, repeats are rescanned and a
//   repeated miss costs another try.
//
// state  | meaning
// IDLE   | waiting for a guess, char_ready high
// SCAN   | comparing word_char to the latched letter, one position per cycle
// UPDATE | charge a miss, then decide win / lose / continue
// DONE   | game over, all outputs frozen until new_game or rst
// ---------------------------------------------------------------------------
module hangman_round_ctrl #(
  parameter int WORD_LEN  = 5,
  parameter int MAX_TRIES = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                new_game,
  input  logic                char_valid,
  input  logic [4:0]          char_in,
  output logic                char_ready,
  output logic [2:0]          word_index,
  input  logic [4:0]          word_char,
  output logic [WORD_LEN-1:0] guessed_mask,
  output logic [2:0]          tries_left,
  output logic                busy,
  output logic                win,
  output logic                lose
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    UPDATE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [2:0]          LAST_IDX   = 3'(WORD_LEN - 1);
  localparam logic [2:0]          TRIES_INIT = 3'(MAX_TRIES);
  localparam logic [WORD_LEN-1:0] MASK_FULL  = '1;
  localparam logic [4:0]          LAST_CHAR  = 5'd25;

  state_t              state, state_nxt;
  logic [4:0]          letter, letter_nxt;
  logic                hit, hit_nxt;
  logic [2:0]          idx, idx_nxt;
  logic [WORD_LEN-1:0] mask, mask_nxt;
  logic [2:0]          tries, tries_nxt;
  logic                win_r, win_nxt;
  logic                lose_r, lose_nxt;

  logic                accept;
  logic                letter_ok;
  logic                is_repeat;
  logic [2:0]          tries_upd;

`ifdef HANGMAN_REPEAT_GUARD_EN
  logic [25:0]         used, used_nxt;
`endif

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      letter <= '0;
      hit    <= 1'b0;
      idx    <= '0;
      mask   <= '0;
      tries  <= TRIES_INIT;
      win_r  <= 1'b0;
      lose_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      letter <= letter_nxt;
      hit    <= hit_nxt;
      idx    <= idx_nxt;
      mask   <= mask_nxt;
      tries  <= tries_nxt;
      win_r  <= win_nxt;
      lose_r <= lose_nxt;
    end
  end

`ifdef HANGMAN_REPEAT_GUARD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      used <= '0;
    end else begin
      used <= used_nxt;
    end
  end
`endif

  // ---------------------------------------------------------------------
  // Handshake qualification
  // ---------------------------------------------------------------------
  assign char_ready = (state == IDLE) && !new_game;
  assign accept     = char_valid && char_ready;
  assign letter_ok  = (char_in <= LAST_CHAR);

`ifdef HANGMAN_REPEAT_GUARD_EN
  // The index is only meaningful for letters A..Z; invalid codes are
  // rejected by letter_ok before this term matters.
  assign is_repeat = letter_ok && used[char_in];
`else
  assign is_repeat = 1'b0;
`endif

  // A miss costs one try, saturating at zero.
  always_comb begin
    tries_upd = tries;
    if (!hit && (tries != 3'd0)) begin
      tries_upd = tries - 3'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    letter_nxt = letter;
    hit_nxt    = hit;
    idx_nxt    = idx;
    mask_nxt   = mask;
    tries_nxt  = tries;
    win_nxt    = win_r;
    lose_nxt   = lose_r;
`ifdef HANGMAN_REPEAT_GUARD_EN
    used_nxt   = used;
`endif

    if (new_game) begin
      // Restart wins in every state; a guess presented together with it
      // is dropped because char_ready is low.
      state_nxt  = IDLE;
      hit_nxt    = 1'b0;
      idx_nxt    = '0;
      mask_nxt   = '0;
      tries_nxt  = TRIES_INIT;
      win_nxt    = 1'b0;
      lose_nxt   = 1'b0;
`ifdef HANGMAN_REPEAT_GUARD_EN
      used_nxt   = '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // Invalid codes and guarded repeats are consumed: the
          // handshake completes but the FSM stays in IDLE.
          if (accept && letter_ok && !is_repeat) begin
            letter_nxt = char_in;
            hit_nxt    = 1'b0;
            idx_nxt    = '0;
            state_nxt  = SCAN;
`ifdef HANGMAN_REPEAT_GUARD_EN
            used_nxt[char_in] = 1'b1;
`endif
          end
        end

        SCAN: begin
          if (word_char == letter) begin
            hit_nxt = 1'b1;
            for (int i = 0; i < WORD_LEN; i++) begin
              if (idx == 3'(i)) begin
                mask_nxt[i] = 1'b1;
              end
            end
          end
          if (idx == LAST_IDX) begin
            idx_nxt   = '0;
            state_nxt = UPDATE;
          end else begin
            idx_nxt   = idx + 3'd1;
          end
        end

        UPDATE: begin
          // The mask is final once SCAN ends. A full mask wins even when
          // the same guess would also exhaust the tries.
          tries_nxt = tries_upd;
          if (mask == MASK_FULL) begin
            win_nxt   = 1'b1;
            state_nxt = DONE;
          end else if (tries_upd == 3'd0) begin
            lose_nxt  = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = IDLE;
          end
        end

        DONE: begin
          state_nxt = DONE;
        end

        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign word_index   = (state == SCAN) ? idx : 3'd0;
  assign busy         = (state == SCAN) || (state == UPDATE);
  assign guessed_mask = mask;
  assign tries_left   = tries;
  assign win          = win_r;
  assign lose         = lose_r;

endmodule

// File: tb/tb_hangman_round_ctrl.sv
module tb_hangman_round_ctrl;

  localparam int WORD_LEN  = 5;
  localparam int MAX_TRIES = 6;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                new_game = 1'b0;
  logic                char_valid = 1'b0;
  logic [4:0]          char_in = '0;
  logic                char_ready;
  logic [2:0]          word_index;
  logic [4:0]          word_char;
  logic [WORD_LEN-1:0] guessed_mask;
  logic [2:0]          tries_left;
  logic                busy;
  logic                win;
  logic                lose;

  int n_tests = 0;
  int n_fail  = 0;

  // word store owned by the bench
  logic [4:0] word [WORD_LEN];

  // reference model: game state as plain numbers
  logic [WORD_LEN-1:0] m_mask;
  int                  m_tries;
  bit                  m_win, m_lose;
  bit                  m_used [26];

  always #5 clk = ~clk;

  always_comb begin
    word_char = 5'd0;
    if (int'(word_index) < WORD_LEN) word_char = word[word_index];
  end

  hangman_round_ctrl #(.WORD_LEN(WORD_LEN), .MAX_TRIES(MAX_TRIES)) dut (
    .clk          (clk),
    .rst          (rst),
    .new_game     (new_game),
    .char_valid   (char_valid),
    .char_in      (char_in),
    .char_ready   (char_ready),
    .word_index   (word_index),
    .word_char    (word_char),
    .guessed_mask (guessed_mask),
    .tries_left   (tries_left),
    .busy         (busy),
    .win          (win),
    .lose         (lose)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_mask  = '0;
    m_tries = MAX_TRIES;
    m_win   = 1'b0;
    m_lose  = 1'b0;
    for (int i = 0; i < 26; i++) m_used[i] = 1'b0;
  endfunction

  // Applies the game rules to one accepted guess; returns 1 if the guess
  // is evaluated (scanned), 0 if it is merely consumed.
  function automatic bit model_guess(input int c);
    bit hit;
    if (c > 25) return 1'b0;
`ifdef HANGMAN_REPEAT_GUARD_EN
    if (m_used[c]) return 1'b0;
`endif
    m_used[c] = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < WORD_LEN; i++) begin
      if (int'(word[i]) == c) begin
        m_mask[i] = 1'b1;
        hit = 1'b1;
      end
    end
    if (!hit && m_tries > 0) m_tries--;
    if (&m_mask) m_win = 1'b1;
    else if (m_tries == 0) m_lose = 1'b1;
    return 1'b1;
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_mask"},  32'(guessed_mask), 32'(m_mask));
    check({tag, "_tries"}, 32'(tries_left),   32'(m_tries));
    check({tag, "_win"},   32'(win),          32'(m_win));
    check({tag, "_lose"},  32'(lose),         32'(m_lose));
  endtask

  task automatic set_hello();
    word[0] = 5'd7; word[1] = 5'd4; word[2] = 5'd11; word[3] = 5'd11; word[4] = 5'd14;
  endtask

  task automatic start_game(input bit with_valid);
    @(negedge clk);
    new_game   = 1'b1;
    char_valid = with_valid;
    char_in    = 5'd0;
    #1;
    check("ready_during_new_game", 32'(char_ready), 32'd0);
    @(posedge clk);
    #1;
    new_game   = 1'b0;
    char_valid = 1'b0;
    model_reset();
    @(negedge clk);
    check("ng_busy", 32'(busy), 32'd0);
    check("ng_ready", 32'(char_ready), 32'd1);
    check_state("ng");
  endtask

  task automatic do_guess(input logic [4:0] c);
    int  n;
    bit  scans;
    @(negedge clk);
    n = 0;
    while (!char_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!char_ready) begin
      check("ready_timeout", 32'(char_ready), 32'd1);
      return;
    end
    scans      = model_guess(int'(c));
    char_valid = 1'b1;
    char_in    = c;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    if (scans) begin
      for (int k = 0; k <= WORD_LEN; k++) begin
        @(negedge clk);
        check("busy_eval", 32'(busy), 32'd1);
        check("ready_eval", 32'(char_ready), 32'd0);
        check("word_index", 32'(word_index), (k < WORD_LEN) ? 32'(k) : 32'd0);
      end
    end
    @(negedge clk);
    check("busy_after", 32'(busy), 32'd0);
    check("ready_after", 32'(char_ready), (m_win || m_lose) ? 32'd0 : 32'd1);
    check_state("guess");
  endtask

  // char_valid while the game is over must change nothing
  task automatic done_poke(input logic [4:0] c);
    @(negedge clk);
    char_valid = 1'b1;
    char_in    = c;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    @(negedge clk);
    check("done_busy", 32'(busy), 32'd0);
    check("done_ready", 32'(char_ready), 32'd0);
    check_state("done_hold");
  endtask

  initial begin
    set_hello();
    model_reset();
    // reset state while rst is held, then after release
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_index", 32'(word_index), 32'd0);
    check_state("rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(char_ready), 32'd1);
    check_state("post_rst");

    // HELLO: L reveals positions 2 and 3, then win
    do_guess(5'd11);
    check("L_mask_const", 32'(guessed_mask), 32'b01100);
    do_guess(5'd7);
    do_guess(5'd4);
    do_guess(5'd14);
    check("win_const", 32'(win), 32'd1);
    done_poke(5'd3);

    // restart with a guess offered in the same cycle
    start_game(1'b1);

    // invalid code is consumed without evaluation
    do_guess(5'd30);
    check("invalid_tries", 32'(tries_left), 32'(MAX_TRIES));

    // six misses of the same letter
    for (int i = 0; i < MAX_TRIES; i++) do_guess(5'd25);
`ifdef HANGMAN_REPEAT_GUARD_EN
    check("repeat_tries", 32'(tries_left), 32'(MAX_TRIES - 1));
`else
    check("miss_lose", 32'(lose), 32'd1);
    done_poke(5'd25);
`endif

    // rst during SCAN abandons the guess
    start_game(1'b0);
    @(negedge clk);
    char_valid = 1'b1;
    char_in    = 5'd11;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_scan_mask", 32'(guessed_mask), 32'b00100);
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_scan_busy", 32'(busy), 32'd0);
    check("rst_scan_index", 32'(word_index), 32'd0);
    check_state("rst_scan");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_scan_ready", 32'(char_ready), 32'd1);

    // randomized games
    for (int g = 0; g < 10; g++) begin
      start_game($urandom_range(0, 1) == 1);
      for (int i = 0; i < WORD_LEN; i++) word[i] = 5'($urandom_range(0, 7));
      for (int t = 0; t < 20; t++) begin
        if (m_win || m_lose) begin
          done_poke(5'($urandom_range(0, 31)));
          break;
        end
        if ($urandom_range(0, 9) == 0) do_guess(5'($urandom_range(26, 31)));
        else do_guess(5'($urandom_range(0, 11)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
